// File: rtl/dca_matrix_move_pkg.sv
// rtl/dca_matrix_move_pkg.sv - shared states and command codes for the matrix move sequencer
package dca_matrix_move_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_SWAP  = 3'd4
  } state_e;

  localparam logic [1:0] CMD_INIT  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_DRAIN = 2'd2;
  localparam logic [1:0] CMD_SWAP  = 2'd3;

  function automatic state_e cmd_to_state(input logic [1:0] code);
    case (code)
      CMD_INIT:  return ST_INIT;
      CMD_LOAD:  return ST_LOAD;
      CMD_DRAIN: return ST_DRAIN;
      default:   return ST_SWAP;
    endcase
  endfunction

endpackage

// File: rtl/dca_matrix_move_sequencer_if.sv
// rtl/dca_matrix_move_sequencer_if.sv - command, abort and row stream bundle of the move sequencer
interface dca_matrix_move_sequencer_if #(
  parameter int BW_TENSOR_ROW = 256
);

  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [1:0]               cmd_code;
  logic                     abort;
  logic                     in_valid;
  logic                     in_ready;
  logic [BW_TENSOR_ROW-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [BW_TENSOR_ROW-1:0] out_data;

  modport master (
    output cmd_valid, cmd_code, abort, in_valid, in_data, out_ready,
    input  cmd_ready, in_ready, out_valid, out_data
  );

  modport slave (
    input  cmd_valid, cmd_code, abort, in_valid, in_data, out_ready,
    output cmd_ready, in_ready, out_valid, out_data
  );

endinterface

// File: rtl/dca_move_row_counter.sv
// rtl/dca_move_row_counter.sv - row counter that wraps to zero after MAX-1 and flags the last row
module dca_move_row_counter #(
  parameter int MAX = 8,
  parameter int CW  = $clog2(MAX)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          terminal
);

  localparam logic [CW-1:0] LAST = CW'(MAX - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign count    = count_q;
  assign terminal = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = terminal ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dca_matrix_move_sequencer.sv
// rtl/dca_matrix_move_sequencer.sv - sequences INIT/LOAD/DRAIN/SWAP row moves on a shifting matrix register
module dca_matrix_move_sequencer
  import dca_matrix_move_pkg::*;
#(
  parameter int MATRIX_NUM_ROW = 8,
  parameter int BW_TENSOR_ROW  = 256
) (
  input  logic                              clk,
  input  logic                              rstp,
  dca_matrix_move_sequencer_if.slave        bus,
  output logic                              reg_init,
  output logic                              reg_move_wenable,
  output logic                              reg_move_renable,
  output logic [BW_TENSOR_ROW-1:0]          reg_move_wdata_list,
  input  logic [BW_TENSOR_ROW-1:0]          reg_move_rdata_list,
  output logic                              busy,
  output logic                              matrix_valid,
  output logic [$clog2(MATRIX_NUM_ROW)-1:0] row_count
);

  state_e state_q, state_d;
  logic   mvalid_q, mvalid_d;
  logic   ready_q, ready_d;

  logic   cmd_rdy;
  logic   cmd_fire;
  logic   in_rdy;
  logic   out_vld;
  logic   wen;
  logic   ren;
  logic   init_stb;
  logic   row_fire;
  logic   cnt_clr;
  logic   cnt_last;

  // ready_q holds cmd_ready low until the first clock after reset release
  assign ready_d = 1'b1;

  assign bus.cmd_ready       = cmd_rdy;
  assign bus.in_ready        = in_rdy;
  assign bus.out_valid       = out_vld;
  assign bus.out_data        = reg_move_rdata_list;
  assign reg_move_wdata_list = bus.in_data;
  assign reg_init            = init_stb;
  assign reg_move_wenable    = wen;
  assign reg_move_renable    = ren;
  assign busy                = (state_q != ST_IDLE);
  assign matrix_valid        = mvalid_q;

  always_comb begin
    state_d  = state_q;
    mvalid_d = mvalid_q;
    cmd_rdy  = (state_q == ST_IDLE) && ready_q && !bus.abort;
    cmd_fire = bus.cmd_valid && cmd_rdy;
    in_rdy   = 1'b0;
    out_vld  = 1'b0;
    wen      = 1'b0;
    ren      = 1'b0;
    init_stb = 1'b0;
    cnt_clr  = 1'b0;
    row_fire = 1'b0;

    if (bus.abort) begin
      state_d  = ST_IDLE;
      mvalid_d = 1'b0;
      cnt_clr  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_fire) begin
            state_d = cmd_to_state(bus.cmd_code);
            cnt_clr = 1'b1;
          end
        end
        ST_INIT: begin
          init_stb = 1'b1;
          mvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
        ST_LOAD: begin
          in_rdy = 1'b1;
          wen    = bus.in_valid;
        end
        ST_DRAIN: begin
          out_vld = 1'b1;
          ren     = bus.out_ready;
        end
        ST_SWAP: begin
          // upmost row leaves and the new row enters downmost in the same move
          out_vld = bus.in_valid;
          in_rdy  = bus.out_ready;
          wen     = bus.in_valid && bus.out_ready;
          ren     = bus.in_valid && bus.out_ready;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      row_fire = wen || ren;
      if (row_fire && cnt_last) begin
        state_d  = ST_IDLE;
        mvalid_d = (state_q != ST_DRAIN);
      end
    end
  end

  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      state_q  <= ST_IDLE;
      mvalid_q <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mvalid_q <= mvalid_d;
      ready_q  <= ready_d;
    end
  end

  dca_move_row_counter #(
    .MAX (MATRIX_NUM_ROW)
  ) u_row_counter (
    .clk      (clk),
    .rst      (rstp),
    .clr      (cnt_clr),
    .inc      (row_fire),
    .count    (row_count),
    .terminal (cnt_last)
  );

endmodule

// File: tb/tb_dca_matrix_move_sequencer.sv
// tb/tb_dca_matrix_move_sequencer.sv - scoreboard bench for the matrix move sequencer
module tb_dca_matrix_move_sequencer;
  import dca_matrix_move_pkg::*;

  localparam int NR = 8;
  localparam int BW = 32;

  logic clk = 1'b0;
  logic rstp = 1'b1;
  always #5 clk = ~clk;

  dca_matrix_move_sequencer_if #(.BW_TENSOR_ROW(BW)) bus();

  logic                  reg_init;
  logic                  reg_move_wenable;
  logic                  reg_move_renable;
  logic [BW-1:0]         wdata;
  logic [BW-1:0]         rdata;
  logic                  busy;
  logic                  matrix_valid;
  logic [$clog2(NR)-1:0] row_count;

  dca_matrix_move_sequencer #(
    .MATRIX_NUM_ROW (NR),
    .BW_TENSOR_ROW  (BW)
  ) dut (
    .clk                 (clk),
    .rstp                (rstp),
    .bus                 (bus),
    .reg_init            (reg_init),
    .reg_move_wenable    (reg_move_wenable),
    .reg_move_renable    (reg_move_renable),
    .reg_move_wdata_list (wdata),
    .reg_move_rdata_list (rdata),
    .busy                (busy),
    .matrix_valid        (matrix_valid),
    .row_count           (row_count)
  );

  // Model of the controlled shifting register; row 0 is upmost
  bit [BW-1:0] mreg [NR];
  bit          s_wen, s_ren, s_init;
  bit [BW-1:0] s_wdata;
  assign rdata = mreg[0];

  int total = 0;
  int bad = 0;
  int wen_cnt = 0;
  int ren_cnt = 0;
  int acc_cnt = 0;
  logic [BW-1:0] exp_out [$];
  logic [BW-1:0] exp_wr [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (s_init) begin
      for (int i = 0; i < NR; i++) mreg[i] <= '0;
    end else if (s_wen || s_ren) begin
      for (int i = 0; i < NR - 1; i++) mreg[i] <= mreg[i+1];
      mreg[NR-1] <= s_wen ? s_wdata : '0;
    end
  end

  always @(negedge clk) begin
    if (rstp) begin
      s_wen  <= 1'b0;
      s_ren  <= 1'b0;
      s_init <= 1'b0;
    end else begin
      if (bus.cmd_valid && bus.cmd_ready) acc_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_out.size() == 0) chk("out_unexpected", 1, 0);
        else chk("out_data", bus.out_data, exp_out.pop_front());
      end
      if (reg_move_wenable) begin
        wen_cnt++;
        if (exp_wr.size() == 0) chk("wen_unexpected", 1, 0);
        else chk("wdata", wdata, exp_wr.pop_front());
      end
      if (reg_move_renable) ren_cnt++;
      s_wen   <= reg_move_wenable;
      s_ren   <= reg_move_renable;
      s_init  <= reg_init;
      s_wdata <= wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cmd_ready();
    int k = 0;
    @(negedge clk);
    while (!bus.cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) chk("cmd_ready_timeout", 1, 0);
    tick();
  endtask

  task automatic send_cmd(input logic [1:0] code);
    bus.cmd_valid = 1'b1;
    bus.cmd_code  = code;
    wait_cmd_ready();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic load_rows(input logic [BW-1:0] base, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      int k = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = base + i;
      exp_wr.push_back(base + i);
      @(negedge clk);
      while (!bus.in_ready && k < 20) begin
        @(negedge clk);
        k++;
      end
      if (k >= 20) chk("in_fire_timeout", 1, 0);
      tick();
      bus.in_valid = 1'b0;
      if (gap && (i % 2 == 0)) tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w0, r0, a0, c;
    bus.cmd_valid = 1'b0;
    bus.cmd_code  = CMD_INIT;
    bus.abort     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_row_count", row_count, 0);
    chk("rst_matrix_valid", matrix_valid, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_strobes", {reg_init, reg_move_wenable, reg_move_renable}, 0);
    tick();
    rstp = 1'b0;
    @(negedge clk);
    chk("cmd_ready_before_first_edge", bus.cmd_ready, 0);
    tick();
    chk("cmd_ready_after_rst", bus.cmd_ready, 1);

    // reset pulse in the middle of a LOAD
    send_cmd(CMD_LOAD);
    load_rows(32'hA1, 3, 1'b0);
    chk("midload_row_count", row_count, 3);
    chk("midload_busy", busy, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hA4;
    rstp = 1'b1;
    #1;
    chk("rstpulse_busy", busy, 0);
    chk("rstpulse_row_count", row_count, 0);
    chk("rstpulse_matrix_valid", matrix_valid, 0);
    tick();
    rstp = 1'b0;
    repeat (3) tick();
    bus.in_valid = 1'b0;
    chk("rstpulse_wen_count", wen_cnt, 3);

    // INIT then gapped LOAD of 0x01..0x08
    send_cmd(CMD_INIT);
    @(negedge clk);
    chk("init_reg_init", reg_init, 1);
    tick();
    chk("init_back_idle", busy, 0);
    chk("init_matrix_valid", matrix_valid, 0);
    w0 = wen_cnt;
    send_cmd(CMD_LOAD);
    load_rows(32'h01, NR, 1'b1);
    chk("load_wen_count", wen_cnt - w0, NR);
    chk("load_matrix_valid", matrix_valid, 1);
    chk("load_cmd_ready", bus.cmd_ready, 1);
    chk("load_row_count", row_count, 0);

    // DRAIN with out_ready toggling
    for (int i = 1; i <= NR; i++) exp_out.push_back(i);
    r0 = ren_cnt;
    send_cmd(CMD_DRAIN);
    c = 0;
    while (busy && c < 40) begin
      bus.out_ready = (c % 2 == 0);
      tick();
      c++;
    end
    if (c >= 40) chk("drain_timeout", 1, 0);
    bus.out_ready = 1'b0;
    chk("drain_ren_count", ren_cnt - r0, NR);
    chk("drain_matrix_valid", matrix_valid, 0);
    chk("drain_exp_left", exp_out.size(), 0);

    // cmd_valid held through a LOAD; the queued SWAP is accepted once
    a0 = acc_cnt;
    bus.cmd_valid = 1'b1;
    bus.cmd_code  = CMD_LOAD;
    wait_cmd_ready();
    bus.cmd_code  = CMD_SWAP;
    load_rows(32'h01, NR, 1'b0);
    chk("held_accepts_during_load", acc_cnt - a0, 1);
    chk("held_cmd_ready_idle", bus.cmd_ready, 1);
    chk("reload_matrix_valid", matrix_valid, 1);
    for (int i = 1; i <= NR; i++) exp_out.push_back(i);
    tick();
    bus.cmd_valid = 1'b0;
    chk("held_second_accept", acc_cnt - a0, 2);
    chk("swap_busy", busy, 1);

    // SWAP 0x11..0x18 in, stalled for two cycles first
    w0 = wen_cnt;
    r0 = ren_cnt;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h11;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      chk("swap_stall_wen", reg_move_wenable, 0);
      chk("swap_stall_in_ready", bus.in_ready, 0);
      chk("swap_stall_out_valid", bus.out_valid, 1);
      tick();
    end
    bus.out_ready = 1'b1;
    load_rows(32'h11, NR, 1'b0);
    bus.out_ready = 1'b0;
    chk("swap_wen_count", wen_cnt - w0, NR);
    chk("swap_ren_count", ren_cnt - r0, NR);
    chk("swap_matrix_valid", matrix_valid, 1);
    chk("swap_busy_done", busy, 0);
    chk("swap_accepts", acc_cnt - a0, 2);

    // abort at row 5 of a DRAIN
    for (int i = 0; i < 5; i++) exp_out.push_back(32'h11 + i);
    r0 = ren_cnt;
    send_cmd(CMD_DRAIN);
    bus.out_ready = 1'b1;
    repeat (5) tick();
    chk("abort_row_count_before", row_count, 5);
    bus.abort = 1'b1;
    @(negedge clk);
    chk("abort_ren", reg_move_renable, 0);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_cmd_ready", bus.cmd_ready, 0);
    tick();
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_matrix_valid", matrix_valid, 0);
    chk("abort_row_count", row_count, 0);
    chk("abort_ren_count", ren_cnt - r0, 5);

    tick();
    chk("final_exp_out_left", exp_out.size(), 0);
    chk("final_exp_wr_left", exp_wr.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dca_matrix_move_sequencer.md
DCA_MATRIX_MOVE_SEQUENCER -- requirements
Module: dca_matrix_move_sequencer

Interface
REQ-001 Parameter MATRIX_NUM_ROW, default 8, SHALL set the number of rows moved per LOAD, DRAIN or SWAP command (min 2).
REQ-002 Parameter BW_TENSOR_ROW, default 256, SHALL set the width of one matrix row (NUM_COL x scalar width).
REQ-003 clk  in  1  SHALL be the single clock for the block.
REQ-004 rstp  in  1  SHALL be the reset: asynchronous, active-high.
REQ-005 cmd_valid/cmd_ready  in/out  1/1  SHALL be the command handshake.
REQ-006 cmd_code  in  2  SHALL select the command: 0 INIT, 1 LOAD, 2 DRAIN, 3 SWAP.
REQ-007 abort  in  1  SHALL be a synchronous abort of the running command.
REQ-008 in_valid/in_ready/in_data  in/out/in  1/1/BW_TENSOR_ROW  SHALL be the input row stream.
REQ-009 out_valid/out_ready/out_data  out/in/out  1/1/BW_TENSOR_ROW  SHALL be the output row stream.
REQ-010 reg_init, reg_move_wenable, reg_move_renable  out  1 each  SHALL drive the controlled matrix register.
REQ-011 reg_move_wdata_list  out  BW_TENSOR_ROW  SHALL carry the row written at the downmost position.
REQ-012 reg_move_rdata_list  in  BW_TENSOR_ROW  SHALL carry the current upmost row of the register.
REQ-013 busy, matrix_valid  out  1 each  SHALL report status.
REQ-014 row_count  out  clog2(MATRIX_NUM_ROW)  SHALL report rows moved in the current command.

Function
REQ-015 States SHALL be IDLE, INIT, LOAD, DRAIN and SWAP; cmd_ready=1 only in IDLE; busy = (state!=IDLE).
REQ-016 On a cmd_valid&cmd_ready fire, the next state SHALL be the one selected by cmd_code; row_count SHALL be cleared to 0.
REQ-017 INIT SHALL last exactly one cycle with reg_init=1, then go to IDLE and clear matrix_valid.
REQ-018 LOAD: in_ready=1; a fire (in_valid&in_ready) SHALL assert reg_move_wenable that same cycle, with reg_move_wdata_list=in_data.
REQ-019 DRAIN: out_valid=1 and out_data=reg_move_rdata_list combinationally; a fire SHALL assert reg_move_renable that same cycle.
REQ-020 SWAP: out_valid=in_valid, in_ready=out_ready; a joint fire SHALL assert both wenable and renable in one cycle, outputting the upmost row while writing the new row downmost.
REQ-021 Each fire SHALL increment row_count; a fire at row_count==MATRIX_NUM_ROW-1 SHALL end the command with a return to IDLE and row_count reset to 0.
REQ-022 LOAD or SWAP completion SHALL set matrix_valid; DRAIN completion SHALL clear it.
REQ-023 DRAIN and SWAP SHALL execute even when matrix_valid=0; no error is flagged.
REQ-024 Outside its own state, each of in_ready, out_valid, reg_move_wenable, reg_move_renable and reg_init SHALL be 0; reg_move_wdata_list SHALL equal in_data at all times.
REQ-025 An abort SHALL suppress all reg_* strobes and handshakes in its cycle, return to IDLE next cycle, zero row_count and clear matrix_valid; in IDLE it SHALL only clear matrix_valid.
REQ-026 abort=1 SHALL block any command fire (cmd_ready forced 0).
REQ-027 No combinational path SHALL exist from cmd_* to the reg_* outputs; the in/out stream paths are combinational by design.

Reset
REQ-028 On rstp=1 the block SHALL asynchronously enter IDLE, with row_count=0, matrix_valid=0 and all strobes 0; cmd_ready SHALL go to 1 only after rstp deasserts.
REQ-029 Reset during a command SHALL discard the partial row count; register contents SHALL NOT be affected by this block.

Structure
REQ-030 The state encoding and the cmd_code constants (CMD_INIT/LOAD/DRAIN/SWAP) SHALL live in a shared package, dca_matrix_move_pkg.
REQ-031 One sub-module is natural: dca_move_row_counter, a wrap-at-max counter with clear and a terminal flag; everything else is flat.

Verification
REQ-032 The bench SHALL cover: rstp pulse mid-LOAD at row 3 -> IDLE next edge, row_count=0, matrix_valid=0, no further wenable.
REQ-033 The bench SHALL cover: INIT then LOAD of rows 0x01..0x08 with gapped in_valid -> exactly 8 wenables, matrix_valid=1, cmd_ready back on the following cycle.
REQ-034 The bench SHALL cover: DRAIN with out_ready toggling 1,0,1 -> rows 0x01..0x08 out in order, renable count 8, matrix_valid=0.
REQ-035 The bench SHALL cover: SWAP with rows 0x11..0x18 in and out_ready stalled 2 cycles -> out 0x01..0x08, no wenable while stalled, matrix_valid=1.
REQ-036 The bench SHALL cover: abort at row 5 of DRAIN -> renable 0 in the abort cycle, IDLE next, matrix_valid=0.
REQ-037 The bench SHALL cover: cmd_valid held during LOAD -> no second accept until IDLE; the 2nd command accepted exactly once.
